// File: rtl/lfu_tracker.sv
// -----------------------------------------------------------------------------
// lfu_tracker
//
// Least-frequently-used slot tracker. N_CH request channels compete for
// CAPACITY resident slots. A request held for HOLD_TICKS consecutive timer
// ticks is confirmed: a resident channel gains one use, a non-resident one is
// inserted. When the set is full, the resident channel with the lowest use
// count is evicted, with ties going to the lowest index. All state advances
// only on clk edges where tick is high.
//
// Optional feature macro: LFU_AGING_EN
//   When defined, every AGE_PERIOD-th tick halves all use counters before
//   that tick's confirm update. When undefined, no aging logic exists.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   tick         in   one-clk timer strobe; state only moves when high
//   req          in   [N_CH] request levels, lowest set index wins
//   light        out  [N_CH] resident flags (registered)
//   occupancy    out  number of resident channels
//   evict_valid  out  one-clk pulse on eviction
//   evict_idx    out  evicted channel, held between evictions
// -----------------------------------------------------------------------------
module lfu_tracker #(
    parameter int N_CH       = 4,
    parameter int CAPACITY   = 3,
    parameter int CNT_W      = 4,
    parameter int HOLD_TICKS = 2,
    parameter int AGE_PERIOD = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [N_CH-1:0]               req,
    output logic [N_CH-1:0]               light,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          evict_valid,
    output logic [$clog2(N_CH)-1:0]       evict_idx
);

    localparam int IDX_W  = $clog2(N_CH);
    localparam int OCC_W  = $clog2(CAPACITY+1);
    localparam int HOLD_W = $clog2(HOLD_TICKS+1);

    generate
        if (N_CH < 2 || CAPACITY < 1 || CAPACITY > N_CH || HOLD_TICKS < 1 ||
            CNT_W < 1 || AGE_PERIOD < 2) begin : g_param_check
            $error("lfu_tracker: illegal parameter combination");
        end
    endgenerate

    // Saturating increment of a use counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]  use_cnt  [N_CH];
    logic [CNT_W-1:0]  use_base [N_CH];
    logic [CNT_W-1:0]  use_next [N_CH];
    logic [HOLD_W-1:0] hold, hold_next;
    logic [IDX_W-1:0]  last_ch, last_next;
    logic [N_CH-1:0]   light_next;
    logic [OCC_W-1:0]  occ_next;
    logic              ev_valid_next;
    logic [IDX_W-1:0]  ev_idx_next;
    logic              any_req;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  victim;
    logic              age_event;

`ifdef LFU_AGING_EN
    localparam int AGE_W = $clog2(AGE_PERIOD);
    logic [AGE_W-1:0] age_cnt;

    // The last count of each period marks the aging tick.
    assign age_event = tick && (age_cnt == AGE_W'(AGE_PERIOD-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (tick) begin
            age_cnt <= age_event ? '0 : age_cnt + AGE_W'(1);
        end
    end
`else
    assign age_event = 1'b0;
`endif

    // Aged counters feed both victim search and the confirm update, so a
    // halving tick is applied before that tick's increment or insertion.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            use_base[i] = age_event ? (use_cnt[i] >> 1) : use_cnt[i];
        end
    end

    // Lowest-index request wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    // Minimum-count resident channel; strict less-than keeps the lowest
    // index on ties.
    always_comb begin
        logic             found;
        logic [CNT_W-1:0] best;
        found  = 1'b0;
        best   = '0;
        victim = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (light[i] && (!found || use_base[i] < best)) begin
                found  = 1'b1;
                best   = use_base[i];
                victim = IDX_W'(i);
            end
        end
    end

    always_comb begin
        light_next    = light;
        occ_next      = occupancy;
        ev_valid_next = 1'b0;
        ev_idx_next   = evict_idx;
        hold_next     = hold;
        last_next     = last_ch;
        for (int i = 0; i < N_CH; i++) begin
            use_next[i] = use_cnt[i];
        end

        if (tick) begin
            for (int i = 0; i < N_CH; i++) begin
                use_next[i] = use_base[i];
            end

            if (!any_req) begin
                hold_next = '0;
            end else begin
                if (sel != last_ch || hold == '0) begin
                    last_next = sel;
                    hold_next = HOLD_W'(1);
                end else if (hold < HOLD_W'(HOLD_TICKS)) begin
                    hold_next = hold + HOLD_W'(1);
                end

                // Hold saturates at HOLD_TICKS, so every tick past the first
                // confirm is itself a confirm.
                if (hold_next == HOLD_W'(HOLD_TICKS)) begin
                    if (light[sel]) begin
                        use_next[sel] = sat_inc(use_base[sel]);
                    end else if (occupancy < OCC_W'(CAPACITY)) begin
                        light_next[sel] = 1'b1;
                        use_next[sel]   = CNT_W'(1);
                        occ_next        = occupancy + OCC_W'(1);
                    end else begin
                        // sel is not resident, so it can never be the victim.
                        light_next[victim] = 1'b0;
                        use_next[victim]   = '0;
                        light_next[sel]    = 1'b1;
                        use_next[sel]      = CNT_W'(1);
                        ev_valid_next      = 1'b1;
                        ev_idx_next        = victim;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light       <= '0;
            occupancy   <= '0;
            evict_valid <= 1'b0;
            evict_idx   <= '0;
            hold        <= '0;
            last_ch     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                use_cnt[i] <= '0;
            end
        end else begin
            light       <= light_next;
            occupancy   <= occ_next;
            evict_valid <= ev_valid_next;
            evict_idx   <= ev_idx_next;
            hold        <= hold_next;
            last_ch     <= last_next;
            for (int i = 0; i < N_CH; i++) begin
                use_cnt[i] <= use_next[i];
            end
        end
    end

endmodule

// File: tb/tb_lfu_tracker.sv
// -----------------------------------------------------------------------------
// tb_lfu_tracker
//
// Directed testbench for lfu_tracker. Three instances share one stimulus:
//   dut      - default parameters
//   dut_sat  - CNT_W=2, for counter saturation
//   dut_full - CAPACITY=N_CH, which must never evict
// -----------------------------------------------------------------------------
module tb_lfu_tracker;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req  = 4'bxxxx;

    logic [3:0] light;
    logic [1:0] occupancy;
    logic       evict_valid;
    logic [1:0] evict_idx;

    logic [3:0] light_s;
    logic [1:0] occupancy_s;
    logic       evict_valid_s;
    logic [1:0] evict_idx_s;

    logic [3:0] light_f;
    logic [2:0] occupancy_f;
    logic       evict_valid_f;
    logic [1:0] evict_idx_f;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int ev_cnt_f = 0;
    int ev_base;

    lfu_tracker dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .light(light), .occupancy(occupancy),
        .evict_valid(evict_valid), .evict_idx(evict_idx)
    );

    lfu_tracker #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .light(light_s), .occupancy(occupancy_s),
        .evict_valid(evict_valid_s), .evict_idx(evict_idx_s)
    );

    lfu_tracker #(.CAPACITY(4)) dut_full (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .light(light_f), .occupancy(occupancy_f),
        .evict_valid(evict_valid_f), .evict_idx(evict_idx_f)
    );

    initial forever #5 clk = ~clk;

    // A pulse is high for exactly one cycle, so one negedge sees it once.
    always @(negedge clk) begin
        if (evict_valid)   ev_cnt++;
        if (evict_valid_f) ev_cnt_f++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_req(input logic [3:0] r);
        @(negedge clk);
        req  = r;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1;
    endtask

    task automatic hold_req(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) tick_req(r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        req  = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1: reset with unknown requests, then idle ticks
        repeat (3) @(negedge clk);
        #1;
        chk("rst_light", 32'(light), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'h0);
        chk("rst_evv", 32'(evict_valid), 32'h0);
        chk("rst_evi", 32'(evict_idx), 32'h0);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        hold_req(4'b0000, 3);
        chk("idle_light", 32'(light), 32'h0);
        chk("idle_occ", 32'(occupancy), 32'h0);
        chk("idle_evcnt", 32'(ev_cnt), 32'h0);

        // 2: fill three slots, then evict the least used (ch2, use=3)
        do_reset();
        ev_base = ev_cnt;
        tick_req(4'b0001);
        chk("ch0_t1_light", 32'(light), 32'h0);
        tick_req(4'b0001);
        chk("ch0_t2_light", 32'(light), 32'b0001);
        chk("ch0_t2_occ", 32'(occupancy), 32'd1);
        hold_req(4'b0001, 4);            // use0 = 5
        idle(2);
        chk("gap_light", 32'(light), 32'b0001);
        hold_req(4'b0010, 6);            // use1 = 5
        chk("ch1_light", 32'(light), 32'b0011);
        hold_req(4'b0100, 4);            // use2 = 3
        chk("fill_light", 32'(light), 32'b0111);
        chk("fill_occ", 32'(occupancy), 32'd3);
        tick_req(4'b1000);
        chk("ch3_t1_light", 32'(light), 32'b0111);
        chk("ch3_t1_evv", 32'(evict_valid), 32'h0);
        tick_req(4'b1000);
        chk("evict_valid", 32'(evict_valid), 32'h1);
        chk("evict_idx", 32'(evict_idx), 32'd2);
        chk("evict_light", 32'(light), 32'b1011);
        chk("evict_occ", 32'(occupancy), 32'd3);
        chk("full_light", 32'(light_f), 32'b1111);
        chk("full_occ", 32'(occupancy_f), 32'd4);
        idle(1);
        chk("evv_drop", 32'(evict_valid), 32'h0);
        chk("evi_held", 32'(evict_idx), 32'd2);
        chk("ev_pulses", 32'(ev_cnt - ev_base), 32'd1);
        // 3: ch3 still held and now resident -> counts, no eviction
        tick_req(4'b1000);
        chk("res_hold_evv", 32'(evict_valid), 32'h0);
        chk("res_hold_light", 32'(light), 32'b1011);

        // 3: ties go to the lowest index
        do_reset();
        hold_req(4'b0001, 2);
        hold_req(4'b0010, 2);
        hold_req(4'b0100, 2);
        hold_req(4'b1000, 2);
        chk("tie_evv", 32'(evict_valid), 32'h1);
        chk("tie_evi", 32'(evict_idx), 32'd0);
        chk("tie_light", 32'(light), 32'b1110);
        // ch0 now evicted; holding it confirms again and re-inserts it
        hold_req(4'b0001, 2);
        chk("tie2_evi", 32'(evict_idx), 32'd1);
        chk("tie2_light", 32'(light), 32'b1101);

        // 4: simultaneous requests, lowest wins; switching restarts hold
        do_reset();
        hold_req(4'b0110, 2);
        chk("simul_light", 32'(light), 32'b0010);
        tick_req(4'b0100);
        chk("switch_light", 32'(light), 32'b0010);
        tick_req(4'b0100);
        chk("switch2_light", 32'(light), 32'b0110);

        // 5: saturation on the CNT_W=2 instance; ch0 must not be the victim
        do_reset();
        hold_req(4'b0001, 10);
        hold_req(4'b0010, 2);
        hold_req(4'b0100, 2);
        chk("sat_fill", 32'(light_s), 32'b0111);
        hold_req(4'b1000, 2);
        chk("sat_evv", 32'(evict_valid_s), 32'h1);
        chk("sat_evi", 32'(evict_idx_s), 32'd1);
        chk("sat_light", 32'(light_s), 32'b1101);

        // 6: async reset mid-hold with three slots full
        do_reset();
        hold_req(4'b0001, 2);
        hold_req(4'b0010, 2);
        hold_req(4'b0100, 2);
        chk("pre_rst_light", 32'(light), 32'b0111);
        tick_req(4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_light", 32'(light), 32'h0);
        chk("async_occ", 32'(occupancy), 32'h0);
        chk("async_evv", 32'(evict_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick_req(4'b1000);
        chk("post_rst_t1", 32'(light), 32'h0);
        tick_req(4'b1000);
        chk("post_rst_t2", 32'(light), 32'b1000);
        chk("post_rst_occ", 32'(occupancy), 32'd1);

        chk("full_never_evicts", 32'(ev_cnt_f), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfu_tracker.md
Name: lfu_tracker

Overview:
Parametrised least-frequently-used slot tracker and the successor to the fixed 4-button/3-light LFU. N_CH request channels compete for CAPACITY resident slots. A request that is held for HOLD_TICKS timer ticks makes its channel resident. While a channel is held, each tick raises its use count. Inserting into a full set evicts the resident channel with the lowest count. The block runs in the clk domain and takes its tick as a single-cycle enable from the timer block.

Parameters:
N_CH, 4, number of request/light channels (>=2)
CAPACITY, 3, maximum simultaneously resident channels (1..N_CH)
CNT_W, 4, use-counter width, saturating
HOLD_TICKS, 2, consecutive ticks a request must be held to confirm (>=1)
AGE_PERIOD, 16, ticks between aging events (only with LFU_AGING_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-clk-wide timer strobe; all state advances only on clk edges with tick=1
req  in  N_CH  request buttons, level, sampled on tick
light  out  N_CH  resident flags, registered
occupancy  out  $clog2(CAPACITY+1)  number of resident channels
evict_valid  out  1  one-clk pulse when an eviction happens
evict_idx  out  $clog2(N_CH)  index of the evicted channel, valid with evict_valid, held otherwise

Behaviour:
- Reset (async assert): light=0, occupancy=0, evict_valid=0, evict_idx=0. All use counters, hold counter and last_ch are cleared. Reset asserted mid-hold discards partial holds.
- Cycles with tick=0 leave all state unchanged, except that evict_valid returns to 0.
- Selection: on a tick, sel = the lowest-index bit set in req. Higher set bits are ignored on that tick.
- Hold tracking on a tick:
  - No req bit set: hold=0.
  - sel != last_ch, or hold==0: last_ch=sel, hold=1.
  - Otherwise: hold=min(hold+1, HOLD_TICKS).
- Confirm occurs when the new hold value equals HOLD_TICKS:
  - If light[sel]=1: use[sel] = sat(use[sel]+1), saturating at 2^CNT_W-1.
  - Else, if occupancy<CAPACITY: light[sel]=1, use[sel]=1, occupancy+1.
  - Else (full): victim = the resident channel with minimum use count; ties go to the lowest index. light[victim]=0 and use[victim]=0. light[sel]=1 and use[sel]=1. Occupancy is unchanged. evict_valid=1 and evict_idx=victim for one clk.
- Holding past confirmation keeps hold at HOLD_TICKS, so every further tick while the request is held counts as a confirm: resident channels increment, and a channel evicted while still held is re-inserted.
- Latency: light, occupancy and evict_* update on the clk edge that samples tick, so they are visible the following cycle.
- Zero use counts on resident channels are legal (after aging) and take part in victim selection normally.
- CAPACITY==N_CH: the block never evicts and evict_valid stays 0.
- Victim search is combinational over N_CH entries with no extra latency.

Optional Feature:
LFU_AGING_EN:
- Defined: a tick counter of width $clog2(AGE_PERIOD) counts ticks. On every AGE_PERIOD-th tick, all use counters shift right by 1 before that tick's confirm update is applied. The tick counter clears on rst.
- Undefined: counters only increase or clear, and no aging logic is instantiated.

Test Plan:
1. Reset with req=X, then release with req=0 and run 3 ticks -> light=0000, occupancy=0, evict_valid never 1.
2. Defaults:
   - Hold ch0 6 ticks -> light[0] rises after tick 2.
   - Then ch1 6 ticks, ch2 4 ticks -> light=0111, occupancy=3.
   - Then ch3 2 ticks -> evict_valid pulse with evict_idx=2, light=1011.
3. Tie: ch0, ch1, ch2 each held exactly 2 ticks (use=1 each), then ch3 held 2 ticks -> evict_idx=0, light=1110.
4. Simultaneous: req=0110 for 2 ticks -> only light[1] set. Then req=0100 for 1 tick -> hold restarts at 1, so light[2] stays 0.
5. Saturation with CNT_W=2: hold ch0 10 ticks -> use[0] stops at 3 and does not wrap. Then fill the other slots and insert ch3 -> ch0 is not the victim.
6. Reset mid-operation: assert rst after 1 tick of a hold and while light=0111 -> all outputs 0 immediately (async). The post-reset hold requires the full HOLD_TICKS again.
